// File: rtl/bi_mem_tp_fifo_if.sv
// Stream and BiMemTp memory-port bundle for bi_mem_tp_fifo.
// The FIFO binds the slave modport; its environment binds the master modport.
interface bi_mem_tp_fifo_if #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
);
    localparam int AW = $clog2(HEIGHT);
    localparam int CW = $clog2(HEIGHT + 3);

    logic             inValid_i;
    logic             inReady_o;
    logic [WIDTH-1:0] inData_i;
    logic             outValid_o;
    logic             outReady_i;
    logic [WIDTH-1:0] outData_o;
    logic [CW-1:0]    fillCount_o;
    logic             memReadEnable_o;
    logic [AW-1:0]    memReadAddr_o;
    logic [WIDTH-1:0] memReadData_i;
    logic             memWriteEnable_o;
    logic [AW-1:0]    memWriteAddr_o;
    logic [WIDTH-1:0] memWriteData_o;

    modport slave (
        input  inValid_i, inData_i, outReady_i, memReadData_i,
        output inReady_o, outValid_o, outData_o, fillCount_o,
               memReadEnable_o, memReadAddr_o,
               memWriteEnable_o, memWriteAddr_o, memWriteData_o
    );

    modport master (
        output inValid_i, inData_i, outReady_i, memReadData_i,
        input  inReady_o, outValid_o, outData_o, fillCount_o,
               memReadEnable_o, memReadAddr_o,
               memWriteEnable_o, memWriteAddr_o, memWriteData_o
    );
endinterface

// File: rtl/bi_mem_tp_fifo.sv
// FIFO controller using an external BiMemTp two-port memory as storage,
// with read prefetch into a two-entry head/skid output buffer.
module bi_mem_tp_fifo #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input logic            clk_i,
    input logic            rst_i,
    bi_mem_tp_fifo_if.slave bus
);
    localparam int AW = $clog2(HEIGHT);
    localparam int CW = $clog2(HEIGHT + 3);
    localparam logic [AW-1:0] LAST = AW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_e;

    buf_e             bufSt_q, bufSt_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]    memCnt_q, memCnt_d, fill_q, fill_d;
    logic             rdPend_q;
    logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic             push, pop, issue;
    logic [2:0]       occ;

    assign bus.inReady_o  = (memCnt_q < CW'(HEIGHT)) && !rst_i;
    assign bus.outValid_o = (bufSt_q != BUF_EMPTY) && !rst_i;
    assign push = bus.inValid_i && bus.inReady_o;
    assign pop  = bus.outValid_o && bus.outReady_i;

    // Occupancy the buffer will have once the in-flight read lands and a pop
    // retires; issuing only while it is <= 1 keeps the skid register sufficient.
    assign occ   = {1'b0, bufSt_q} + {2'b00, rdPend_q} - {2'b00, pop};
    assign issue = !rst_i && (memCnt_q != '0) && (occ <= 3'd1);

    assign bus.memWriteEnable_o = push;
    assign bus.memWriteAddr_o   = wrPtr_q;
    assign bus.memWriteData_o   = bus.inData_i;
    assign bus.memReadEnable_o  = issue;
    assign bus.memReadAddr_o    = rdPtr_q;
    assign bus.outData_o        = head_q;
    assign bus.fillCount_o      = fill_q;

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        if (push) wrPtr_d = (wrPtr_q == LAST) ? '0 : wrPtr_q + 1'b1;
        if (issue) rdPtr_d = (rdPtr_q == LAST) ? '0 : rdPtr_q + 1'b1;
        memCnt_d = memCnt_q + CW'(push) - CW'(issue);
        fill_d   = fill_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        bufSt_d = bufSt_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (bufSt_q)
            BUF_EMPTY: begin
                if (rdPend_q) begin
                    head_d  = bus.memReadData_i;
                    bufSt_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (pop && rdPend_q) begin
                    head_d = bus.memReadData_i;
                end else if (pop) begin
                    bufSt_d = BUF_EMPTY;
                end else if (rdPend_q) begin
                    skid_d  = bus.memReadData_i;
                    bufSt_d = BUF_TWO;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    if (rdPend_q) skid_d = bus.memReadData_i;
                    else          bufSt_d = BUF_ONE;
                end
            end
            default: bufSt_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bufSt_q  <= BUF_EMPTY;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            memCnt_q <= '0;
            fill_q   <= '0;
            rdPend_q <= 1'b0;
            head_q   <= '0;
            skid_q   <= '0;
        end else begin
            bufSt_q  <= bufSt_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            memCnt_q <= memCnt_d;
            fill_q   <= fill_d;
            rdPend_q <= issue;
            head_q   <= head_d;
            skid_q   <= skid_d;
        end
    end
endmodule

// File: tb/tb_bi_mem_tp_fifo.sv
// Drives HEIGHT=16 and HEIGHT=5 FIFOs with identical stimulus, each with its own
// BiMemTp memory model and a queue-based reference model.
module tb_bi_mem_tp_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic [15:0] inData = '0;
    logic        outReady = 1'b0;
    int          ntests = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    bi_mem_tp_fifo_if #(.WIDTH(16), .HEIGHT(16)) f0 ();
    bi_mem_tp_fifo_if #(.WIDTH(16), .HEIGHT(5))  f1 ();

    assign f0.inValid_i = inValid;
    assign f0.inData_i = inData;
    assign f0.outReady_i = outReady;
    assign f1.inValid_i = inValid;
    assign f1.inData_i = inData;
    assign f1.outReady_i = outReady;

    bi_mem_tp_fifo #(.WIDTH(16), .HEIGHT(16)) dut0 (.clk_i(clk), .rst_i(rst), .bus(f0.slave));
    bi_mem_tp_fifo #(.WIDTH(16), .HEIGHT(5))  dut1 (.clk_i(clk), .rst_i(rst), .bus(f1.slave));

    logic [15:0] mem0 [16];
    logic [15:0] mem1 [5];

    always @(posedge clk) begin
        if (f0.memWriteEnable_o) mem0[f0.memWriteAddr_o] <= f0.memWriteData_o;
        if (f0.memReadEnable_o) f0.memReadData_i <= mem0[f0.memReadAddr_o];
        if (f1.memWriteEnable_o) mem1[f1.memWriteAddr_o] <= f1.memWriteData_o;
        if (f1.memReadEnable_o) f1.memReadData_i <= mem1[f1.memReadAddr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: word counts in memory / in flight / buffered, plus the
    // ordered queue of every accepted word not yet consumed.
    int          mc [2];
    int          pd [2];
    int          bc [2];
    int          nw [2];
    int          nr [2];
    logic [15:0] q  [2][$];

    task automatic step_model(input int i, input int h, input logic inRdy, input logic oV,
                              input logic [15:0] oD, input logic [31:0] fill,
                              input logic we, input logic [31:0] wa, input logic [15:0] wd,
                              input logic re, input logic [31:0] ra);
        string p;
        bit    psh, pp, iss;
        p = (i == 0) ? "h16" : "h5";
        if (rst) begin
            check({p, ".rst.inReady"}, 32'(inRdy), 0);
            check({p, ".rst.outValid"}, 32'(oV), 0);
            check({p, ".rst.memWE"}, 32'(we), 0);
            check({p, ".rst.memRE"}, 32'(re), 0);
            mc[i] = 0; pd[i] = 0; bc[i] = 0; nw[i] = 0; nr[i] = 0;
            q[i].delete();
            return;
        end
        psh = inValid && (mc[i] < h);
        pp  = (bc[i] != 0) && outReady;
        iss = (mc[i] != 0) && (bc[i] + pd[i] - int'(pp) <= 1);
        check({p, ".inReady"}, 32'(inRdy), 32'(mc[i] < h));
        check({p, ".outValid"}, 32'(oV), 32'(bc[i] != 0));
        if (bc[i] != 0) begin
            if (q[i].size() == 0) check({p, ".model.empty"}, 1, 0);
            else check({p, ".outData"}, 32'(oD), 32'(q[i][0]));
        end
        check({p, ".fill"}, fill, mc[i] + pd[i] + bc[i]);
        check({p, ".memWE"}, 32'(we), 32'(psh));
        if (psh) begin
            check({p, ".memWA"}, wa, nw[i] % h);
            check({p, ".memWD"}, 32'(wd), 32'(inData));
        end
        check({p, ".memRE"}, 32'(re), 32'(iss));
        if (iss) check({p, ".memRA"}, ra, nr[i] % h);
        if (psh) begin q[i].push_back(inData); nw[i]++; end
        if (pp && q[i].size() != 0) void'(q[i].pop_front());
        if (iss) nr[i]++;
        bc[i] = bc[i] - int'(pp) + pd[i];
        pd[i] = int'(iss);
        mc[i] = mc[i] + int'(psh) - int'(iss);
    endtask

    task automatic tick();
        @(negedge clk);
        step_model(0, 16, f0.inReady_o, f0.outValid_o, f0.outData_o, 32'(f0.fillCount_o),
                   f0.memWriteEnable_o, 32'(f0.memWriteAddr_o), f0.memWriteData_o,
                   f0.memReadEnable_o, 32'(f0.memReadAddr_o));
        step_model(1, 5, f1.inReady_o, f1.outValid_o, f1.outData_o, 32'(f1.fillCount_o),
                   f1.memWriteEnable_o, 32'(f1.memWriteAddr_o), f1.memWriteData_o,
                   f1.memReadEnable_o, 32'(f1.memReadAddr_o));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          acc;
        int          k;
        int          cnt;
        int          cyc;
        bit          held;
        logic [15:0] heldData;

        // Reset held two cycles with input offered
        rst = 1'b1; inValid = 1'b1; inData = 16'h1234; outReady = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst.inReady", 32'(f0.inReady_o), 0);
            check("rst.memWE", 32'(f0.memWriteEnable_o), 0);
            tick();
        end
        rst = 1'b0; inValid = 1'b0;
        #1;
        check("post_rst.inReady", 32'(f0.inReady_o), 1);
        check("post_rst.fill", 32'(f0.fillCount_o), 0);
        check("post_rst.outValid", 32'(f0.outValid_o), 0);

        // Latency from a single push into an empty FIFO
        outReady = 1'b1; inValid = 1'b1; inData = 16'hA5A5;
        tick();
        inValid = 1'b0;
        check("lat.re_c1", 32'(f0.memReadEnable_o), 1);
        check("lat.ra_c1", 32'(f0.memReadAddr_o), 0);
        tick();
        check("lat.ov_c2", 32'(f0.outValid_o), 0);
        tick();
        check("lat.ov_c3", 32'(f0.outValid_o), 1);
        check("lat.data_c3", 32'(f0.outData_o), 32'h0000A5A5);
        tick();
        check("lat.fill_c4", 32'(f0.fillCount_o), 0);

        // Fill to full with the consumer stalled, then drain
        outReady = 1'b0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            inValid = 1'b1; inData = 16'(i);
            if (f0.inReady_o) acc++;
            tick();
        end
        inValid = 1'b0;
        tick();
        check("full.accepted", acc, 18);
        check("full.inReady", 32'(f0.inReady_o), 0);
        check("full.fill16", 32'(f0.fillCount_o), 18);
        check("full.fill5", 32'(f1.fillCount_o), 7);
        outReady = 1'b1; k = 0;
        for (int g = 0; g < 40 && f0.outValid_o; g++) begin
            check("drain.data", 32'(f0.outData_o), k);
            k++;
            tick();
        end
        check("drain.count", k, 18);
        check("drain.outValid", 32'(f0.outValid_o), 0);

        // Streaming through the HEIGHT=5 instance wraps its pointers repeatedly
        cnt = 0;
        for (int c = 0; c < 106; c++) begin
            inValid = (c < 100); inData = 16'(1000 + c);
            if (c >= 3 && c < 103 && f1.outValid_o) cnt++;
            tick();
        end
        inValid = 1'b0;
        check("wrap.throughput", cnt, 100);
        check("wrap.fill5", 32'(f1.fillCount_o), 0);

        // Random handshakes on both sides
        cyc = 0; held = 1'b0; heldData = '0;
        while (nw[0] < 10000 && cyc < 60000) begin
            inValid = 1'($urandom_range(0, 1));
            inData = 16'($urandom);
            outReady = 1'($urandom_range(0, 1));
            #1;
            if (held) check("rand.stable", 32'(f0.outData_o), 32'(heldData));
            held = f0.outValid_o && !outReady;
            heldData = f0.outData_o;
            tick();
            cyc++;
        end
        check("rand.completed", 32'(nw[0] >= 10000), 1);

        // Reset in the cycle where read data returns
        inValid = 1'b0; outReady = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; inValid = 1'b1; inData = 16'h1111;
        tick();
        inValid = 1'b0;
        check("mid.re", 32'(f0.memReadEnable_o), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid.fill", 32'(f0.fillCount_o), 0);
        tick();
        tick();
        check("mid.outValid", 32'(f0.outValid_o), 0);
        outReady = 1'b1; inValid = 1'b1; inData = 16'h2222;
        tick();
        inValid = 1'b0;
        for (int g = 0; g < 10 && !f0.outValid_o; g++) tick();
        check("mid.first_valid", 32'(f0.outValid_o), 1);
        check("mid.first_data", 32'(f0.outData_o), 32'h00002222);
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
